// File: rtl/variable_pkg.sv
// variable_pkg: shared ON/OFF levels and turn sequencer state encoding
package variable_pkg;
    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;
    typedef enum logic [1:0] {
        TS_PLAY    = 2'd0,
        TS_HOLDOFF = 2'd1,
        TS_OVER    = 2'd2
    } turn_state_t;
endpackage

// File: rtl/fall_detect.sv
// fall_detect: registers a flag vector and flags bits that dropped since the previous cycle
module fall_detect
    import variable_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk60MHz,
    input  logic         rst,
    input  logic [W-1:0] flag,
    output logic [W-1:0] fall
);
    logic [W-1:0] flag_pre;
    always_ff @(posedge clk60MHz)
        flag_pre <= rst ? {W{OFF}} : flag;
    assign fall = flag_pre & ~flag;
endmodule

// File: rtl/turn_sequencer.sv
// turn_sequencer: turn/active-player tracker with hold-off, game-over and restart; TURN_TIMEOUT_EN adds a forced-advance timeout
module turn_sequencer
    import variable_pkg::*;
#(
    parameter int NUM_PLAYERS    = 2,
    parameter int TURN_W         = 3,
    parameter int MAX_TURN       = 7,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 600_000_000
) (
    input  logic                   clk60MHz,
    input  logic                   rst,
    input  logic [NUM_PLAYERS-1:0] throw_flag,
    input  logic                   new_game,
    output logic [TURN_W-1:0]      turn,
    output logic [NUM_PLAYERS-1:0] active_player,
    output logic                   turn_advance,
    output logic                   game_over,
    output logic                   timeout_pulse
);
    localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);
    turn_state_t      state;
    logic [HO_W-1:0]  hold_cnt;
    logic [NUM_PLAYERS-1:0] fall;
    logic active_flag, valid, tmo_hit, advance;

    fall_detect #(.W(NUM_PLAYERS)) u_fall (
        .clk60MHz(clk60MHz),
        .rst(rst),
        .flag(throw_flag),
        .fall(fall)
    );

    assign active_flag = |(throw_flag & active_player);
    assign valid       = state == TS_PLAY && |(fall & active_player);
    assign advance     = valid | tmo_hit;

`ifdef TURN_TIMEOUT_EN
    localparam int TMO_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0] tmo_cnt;
    // A flight in progress holds the counter at zero, so it is never cut short
    assign tmo_hit = state == TS_PLAY && !active_flag && tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk60MHz) begin
        tmo_cnt       <= (rst || new_game || state != TS_PLAY || active_flag || advance) ? '0 : tmo_cnt + 1'b1;
        timeout_pulse <= (rst || new_game) ? OFF : tmo_hit & ~valid;
    end
`else
    assign tmo_hit       = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    always_ff @(posedge clk60MHz) begin
        if (rst || new_game) begin
            state         <= TS_PLAY;
            turn          <= TURN_W'(1);
            active_player <= NUM_PLAYERS'(1);
            turn_advance  <= OFF;
            game_over     <= OFF;
            hold_cnt      <= '0;
        end else begin
            turn_advance <= OFF;
            case (state)
                TS_PLAY:
                    if (advance) begin
                        turn_advance <= ON;
                        hold_cnt     <= '0;
                        if (turn == TURN_W'(MAX_TURN)) begin
                            active_player <= '0;
                            game_over     <= ON;
                            state         <= TS_OVER;
                        end else begin
                            turn          <= turn + TURN_W'(1);
                            active_player <= {active_player[NUM_PLAYERS-2:0], active_player[NUM_PLAYERS-1]};
                            state         <= TS_HOLDOFF;
                        end
                    end
                TS_HOLDOFF:
                    if (hold_cnt == HO_W'(HOLDOFF_CYCLES - 1))
                        state <= TS_PLAY;
                    else
                        hold_cnt <= hold_cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule
